alarm_ringer: RTL and testbench

ALARM_RINGER -- requirements
Module: alarm_ringer

---
 rtl/alarm_ringer.sv | 137 +++++++++++++
 tb/tb_alarm_ringer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm ring/snooze sequencer; snooze path built only when ALARM_SNOOZE_EN is defined
module alarm_ringer #(
  parameter int ring_seconds   = 60,
  parameter int snooze_minutes = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic [7:0] second_data,
  input  logic [7:0] minute_data,
  input  logic [7:0] hour_data,
  input  logic [7:0] alarm_minute,
  input  logic [7:0] alarm_hour,
  input  logic       stop,
  input  logic       snooze,
  output logic       ring,
  output logic       buzz,
  output logic       snoozing
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [7:0] RING_LAST = 8'(ring_seconds);

  state_t     state;
  state_t     state_next;
  logic       match;
  logic       match_q;
  logic       trigger;
  logic [7:0] ring_cnt;
  logic [7:0] ring_cnt_inc;
  logic       beat;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNOOZE_LOAD = 10'(snooze_minutes * 60);
  logic [9:0] snooze_cnt;
`else
  // snooze pulse has no effect when the snooze path is not built
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // raw byte compare of the BCD time fields; fires only at second zero
  assign match = alarm_en & (hour_data == alarm_hour) & (minute_data == alarm_minute)
               & (second_data == 8'h00);
  assign trigger      = match & ~match_q;
  assign ring_cnt_inc = ring_cnt + 8'd1;

  // match history; reset high so a time already matching at release does not fire
  always_ff @(posedge clock) begin
    if (!reset) match_q <= 1'b1;
    else        match_q <= match;
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // next state: alarm_en low, then stop, then snooze, then tick-driven moves
  always_comb begin
    state_next = state;
    if (!alarm_en) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (trigger) state_next = RING;
        end
        RING: begin
          if (stop) state_next = IDLE;
`ifdef ALARM_SNOOZE_EN
          else if (snooze) state_next = SNOOZE;
`endif
          else if (tick_1hz && (ring_cnt_inc == RING_LAST)) state_next = IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (stop) state_next = IDLE;
          else if (tick_1hz && (snooze_cnt == 10'd1)) state_next = RING;
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // ring second counter and buzzer beat; restart only on entry to RING
  always_ff @(posedge clock) begin
    if (!reset) begin
      ring_cnt <= 8'd0;
      beat     <= 1'b0;
    end else if (state_next != RING) begin
      ring_cnt <= 8'd0;
      beat     <= 1'b0;
    end else if (state != RING) begin
      ring_cnt <= 8'd0;
      beat     <= 1'b1;
    end else if (tick_1hz) begin
      ring_cnt <= ring_cnt_inc;
      beat     <= ~beat;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // snooze countdown in seconds; loaded on entry, never decremented below zero
  always_ff @(posedge clock) begin
    if (!reset) begin
      snooze_cnt <= 10'd0;
    end else if (state_next != SNOOZE) begin
      snooze_cnt <= 10'd0;
    end else if (state != SNOOZE) begin
      snooze_cnt <= SNOOZE_LOAD;
    end else if (tick_1hz && (snooze_cnt != 10'd0)) begin
      snooze_cnt <= snooze_cnt - 10'd1;
    end
  end
`endif

  // outputs decoded straight from registered state and beat
  always_comb begin
    ring     = (state == RING);
    buzz     = (state == RING) & beat;
`ifdef ALARM_SNOOZE_EN
    snoozing = (state == SNOOZE);
`else
    snoozing = 1'b0;
`endif
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - directed self-checking bench for alarm_ringer
module tb_alarm_ringer;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       alarm_en;
  logic [7:0] second_data;
  logic [7:0] minute_data;
  logic [7:0] hour_data;
  logic [7:0] alarm_minute;
  logic [7:0] alarm_hour;
  logic       stop;
  logic       snooze;
  logic       ring;
  logic       buzz;
  logic       snoozing;

  int checks = 0;
  int errors = 0;

  alarm_ringer dut (
    .clock        (clock),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .alarm_en     (alarm_en),
    .second_data  (second_data),
    .minute_data  (minute_data),
    .hour_data    (hour_data),
    .alarm_minute (alarm_minute),
    .alarm_hour   (alarm_hour),
    .stop         (stop),
    .snooze       (snooze),
    .ring         (ring),
    .buzz         (buzz),
    .snoozing     (snoozing)
  );

  always #5 clock = ~clock;

  // advance one clock; returns at the falling edge so outputs are settled
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    cyc();
  endtask

  // alarm 07:30, time steps 07:29:59 -> 07:30:00; RING is entered on the second edge
  task automatic start_ring();
    alarm_hour   = 8'h07;
    alarm_minute = 8'h30;
    hour_data    = 8'h07;
    minute_data  = 8'h29;
    second_data  = 8'h59;
    cyc();
    minute_data  = 8'h30;
    second_data  = 8'h00;
    cyc();
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    alarm_en     = 1'b1;
    hour_data    = 8'h06;
    minute_data  = 8'h00;
    second_data  = 8'h00;
    alarm_hour   = 8'h06;
    alarm_minute = 8'h00;
    repeat (3) cyc();
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL reset_ring got=%b exp=0", ring); end
    checks++;
    if (buzz !== 1'b0) begin errors++; $display("FAIL reset_buzz got=%b exp=0", buzz); end
    checks++;
    if (snoozing !== 1'b0) begin errors++; $display("FAIL reset_snoozing got=%b exp=0", snoozing); end
    reset = 1'b1;
    repeat (3) cyc();
    pulse_tick();
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL release_match_ring got=%b exp=0", ring); end
  endtask

  task automatic test_auto_off();
    logic exp_buzz;
    start_ring();
    checks++;
    if (ring !== 1'b1) begin errors++; $display("FAIL start_ring got=%b exp=1", ring); end
    checks++;
    if (buzz !== 1'b1) begin errors++; $display("FAIL start_buzz got=%b exp=1", buzz); end
    for (int k = 1; k <= 59; k++) begin
      pulse_tick();
      exp_buzz = ((k % 2) == 0);
      checks++;
      if (ring !== 1'b1) begin errors++; $display("FAIL ring_hold tick=%0d got=%b exp=1", k, ring); end
      checks++;
      if (buzz !== exp_buzz) begin errors++; $display("FAIL buzz_pattern tick=%0d got=%b exp=%b", k, buzz, exp_buzz); end
    end
    pulse_tick();
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL auto_off_ring got=%b exp=0", ring); end
    checks++;
    if (buzz !== 1'b0) begin errors++; $display("FAIL auto_off_buzz got=%b exp=0", buzz); end
  endtask

  task automatic test_retrigger();
    start_ring();
    repeat (30) pulse_tick();
    second_data = 8'h01;
    cyc();
    second_data = 8'h00;
    cyc();
    repeat (29) pulse_tick();
    checks++;
    if (ring !== 1'b1) begin errors++; $display("FAIL retrig_hold got=%b exp=1", ring); end
    pulse_tick();
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL retrig_no_restart got=%b exp=0", ring); end
  endtask

  task automatic test_stop();
    start_ring();
    pulse_tick();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL stop_ring got=%b exp=0", ring); end
  endtask

  task automatic test_stop_and_snooze();
    start_ring();
    stop   = 1'b1;
    snooze = 1'b1;
    cyc();
    stop   = 1'b0;
    snooze = 1'b0;
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL stop_snooze_ring got=%b exp=0", ring); end
    checks++;
    if (snoozing !== 1'b0) begin errors++; $display("FAIL stop_snooze_snoozing got=%b exp=0", snoozing); end
  endtask

  task automatic test_alarm_en_drop();
    start_ring();
    pulse_tick();
    checks++;
    if (buzz !== 1'b0) begin errors++; $display("FAIL drop_buzz_t1 got=%b exp=0", buzz); end
    pulse_tick();
    checks++;
    if (buzz !== 1'b1) begin errors++; $display("FAIL drop_buzz_t2 got=%b exp=1", buzz); end
    alarm_en = 1'b0;
    cyc();
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL drop_ring got=%b exp=0", ring); end
    checks++;
    if (buzz !== 1'b0) begin errors++; $display("FAIL drop_buzz got=%b exp=0", buzz); end
    second_data = 8'h59;
    cyc();
    alarm_en = 1'b1;
    cyc();
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    start_ring();
    repeat (2) pulse_tick();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL snooze_enter_ring got=%b exp=0", ring); end
    checks++;
    if (snoozing !== 1'b1) begin errors++; $display("FAIL snooze_enter got=%b exp=1", snoozing); end
    for (int k = 1; k <= 299; k++) begin
      pulse_tick();
      if (k == 100) begin
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
      end
    end
    checks++;
    if (snoozing !== 1'b1) begin errors++; $display("FAIL snooze_hold got=%b exp=1", snoozing); end
    pulse_tick();
    checks++;
    if (snoozing !== 1'b0) begin errors++; $display("FAIL snooze_expire got=%b exp=0", snoozing); end
    checks++;
    if (ring !== 1'b1) begin errors++; $display("FAIL snooze_rering got=%b exp=1", ring); end
    checks++;
    if (buzz !== 1'b1) begin errors++; $display("FAIL snooze_rebuzz got=%b exp=1", buzz); end
    repeat (59) pulse_tick();
    checks++;
    if (ring !== 1'b1) begin errors++; $display("FAIL rering_hold got=%b exp=1", ring); end
    pulse_tick();
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL rering_off got=%b exp=0", ring); end
    second_data = 8'h59;
    cyc();
    start_ring();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    pulse_tick();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (snoozing !== 1'b0) begin errors++; $display("FAIL snooze_stop got=%b exp=0", snoozing); end
  endtask
`else
  task automatic test_snooze();
    start_ring();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
    checks++;
    if (ring !== 1'b1) begin errors++; $display("FAIL nosnooze_ring got=%b exp=1", ring); end
    checks++;
    if (snoozing !== 1'b0) begin errors++; $display("FAIL nosnooze_snoozing got=%b exp=0", snoozing); end
    repeat (3) pulse_tick();
    checks++;
    if (ring !== 1'b1) begin errors++; $display("FAIL nosnooze_hold got=%b exp=1", ring); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (ring !== 1'b0) begin errors++; $display("FAIL nosnooze_stop got=%b exp=0", ring); end
  endtask
`endif

  initial begin
    reset        = 1'b0;
    tick_1hz     = 1'b0;
    alarm_en     = 1'b0;
    second_data  = 8'h00;
    minute_data  = 8'h00;
    hour_data    = 8'h00;
    alarm_minute = 8'h00;
    alarm_hour   = 8'h00;
    stop         = 1'b0;
    snooze       = 1'b0;
    cyc();
    test_reset();
    test_auto_off();
    test_retrigger();
    test_stop();
    test_stop_and_snooze();
    test_alarm_en_drop();
    test_snooze();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
